// File: rtl/reg_file_pkg.sv
// Shared defaults, address-width helper and address type for the register file.
package reg_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_RD   = 2;

  function automatic int addr_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  localparam int DEF_AW = addr_w(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits, issue handshake and registered busy population count.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int  NUM_REGS = DEF_NUM_REGS,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_reg,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_reg,
  output logic                issue_ready,
  output logic [NUM_REGS-1:0] busy,
  output logic [AW:0]         busy_count
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [AW:0]         count_nxt;
  logic                wr_hit;
  logic                set_hit;

  // A write releasing the issued register this cycle lets the reissue through;
  // the set is applied after the clear so it wins on a collision.
  always_comb begin
    wr_hit      = wr_en && (wr_reg != '0);
    issue_ready = (issue_reg == '0) || !busy[issue_reg] || (wr_en && (wr_reg == issue_reg));
    set_hit     = issue_valid && issue_ready && (issue_reg != '0);
    busy_nxt    = busy;
    if (wr_hit) busy_nxt[wr_reg] = 1'b0;
    if (set_hit) busy_nxt[issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
    count_nxt   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_nxt = count_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-pending scoreboard.
// Optional same-cycle write-to-read bypass: define REG_FILE_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_RD   = DEF_NUM_RD,
  localparam int AW       = addr_w(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Reg_Write,
  input  logic [AW-1:0]          Write_Reg,
  input  logic [DATA_W-1:0]      Write_Data,
  input  logic [NUM_RD*AW-1:0]   Read_Reg,
  output logic [NUM_RD*DATA_W-1:0] Read_Data,
  output logic [NUM_RD-1:0]      Read_Busy,
  input  logic                   Issue_Valid,
  input  logic [AW-1:0]          Issue_Reg,
  output logic                   Issue_Ready,
  output logic [AW:0]            Busy_Count
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [AW-1:0]       rd_addr;

  reg_file_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (Reg_Write),
    .wr_reg      (Write_Reg),
    .issue_valid (Issue_Valid),
    .issue_reg   (Issue_Reg),
    .issue_ready (Issue_Ready),
    .busy        (busy),
    .busy_count  (Busy_Count)
  );

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (Reg_Write && (Write_Reg != '0)) begin
      regs[Write_Reg] <= Write_Data;
    end
  end

  always_comb begin
    Read_Data = '0;
    Read_Busy = '0;
    rd_addr   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = Read_Reg[i*AW +: AW];
      Read_Data[i*DATA_W +: DATA_W] = regs[rd_addr];
      Read_Busy[i] = busy[rd_addr];
`ifdef REG_FILE_BYPASS_EN
      if (rst_n && Reg_Write && (Write_Reg != '0) && (Write_Reg == rd_addr)) begin
        Read_Data[i*DATA_W +: DATA_W] = Write_Data;
        Read_Busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard-style bench for reg_file_mp: expectations queued at stimulus, checked at negedge.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int RD = 2;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             Reg_Write = 1'b0;
  logic [AW-1:0]    Write_Reg = '0;
  logic [DW-1:0]    Write_Data = '0;
  logic [RD*AW-1:0] Read_Reg = '0;
  logic [RD*DW-1:0] Read_Data;
  logic [RD-1:0]    Read_Busy;
  logic             Issue_Valid = 1'b0;
  logic [AW-1:0]    Issue_Reg = '0;
  logic             Issue_Ready;
  logic [AW:0]      Busy_Count;

  reg_file_mp dut (
    .clk(clk), .rst_n(rst_n), .Reg_Write(Reg_Write), .Write_Reg(Write_Reg),
    .Write_Data(Write_Data), .Read_Reg(Read_Reg), .Read_Data(Read_Data),
    .Read_Busy(Read_Busy), .Issue_Valid(Issue_Valid), .Issue_Reg(Issue_Reg),
    .Issue_Ready(Issue_Ready), .Busy_Count(Busy_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [RD*DW-1:0] rd;
    logic [RD-1:0]    rb;
    logic             rdy;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [DW-1:0] mregs [NR];
  bit          mbusy [NR];

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  // Monitor: every negedge that has a pending expectation is compared here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < RD; p++) begin
          tests++;
          if (Read_Data[p*DW +: DW] !== e.rd[p*DW +: DW]) begin
            fails++;
            $display("FAIL %s read_data[%0d]: got %h, expected %h", e.name, p, Read_Data[p*DW +: DW], e.rd[p*DW +: DW]);
          end
          tests++;
          if (Read_Busy[p] !== e.rb[p]) begin
            fails++;
            $display("FAIL %s read_busy[%0d]: got %b, expected %b", e.name, p, Read_Busy[p], e.rb[p]);
          end
        end
        tests++;
        if (Issue_Ready !== e.rdy) begin
          fails++;
          $display("FAIL %s issue_ready: got %b, expected %b", e.name, Issue_Ready, e.rdy);
        end
        tests++;
        if (Busy_Count !== e.cnt) begin
          fails++;
          $display("FAIL %s busy_count: got %0d, expected %0d", e.name, Busy_Count, e.cnt);
        end
      end
    end
  end

  // One cycle: drive, queue expectation from the model, let the edge happen, update the model.
  task automatic cycle(input bit we, input int wreg, input logic [DW-1:0] wdata,
                       input bit iv, input int ireg, input int ra0, input int ra1, input string name);
    exp_t e;
    int   ra[RD];
    bit   rdy;
    ra[0] = ra0;
    ra[1] = ra1;
    Reg_Write   = we;
    Write_Reg   = AW'(wreg);
    Write_Data  = wdata;
    Issue_Valid = iv;
    Issue_Reg   = AW'(ireg);
    Read_Reg    = {AW'(ra1), AW'(ra0)};
    e.name = name;
    e.rd   = '0;
    e.rb   = '0;
    for (int p = 0; p < RD; p++) begin
      e.rd[p*DW +: DW] = mregs[ra[p]];
      e.rb[p]          = mbusy[ra[p]];
`ifdef REG_FILE_BYPASS_EN
      if (rst_n && we && wreg != 0 && wreg == ra[p]) begin
        e.rd[p*DW +: DW] = wdata;
        e.rb[p]          = 1'b0;
      end
`endif
    end
    rdy   = (ireg == 0) || !mbusy[ireg] || (we && wreg == ireg);
    e.rdy = rdy;
    e.cnt = (AW+1)'(model_count());
    exp_q.push_back(e);
    @(negedge clk);
    @(posedge clk);
    if (rst_n) begin
      if (we && wreg != 0) begin
        mregs[wreg] = wdata;
        mbusy[wreg] = 1'b0;
      end
      if (iv && rdy && ireg != 0) mbusy[ireg] = 1'b1;
    end
    #1;
  endtask

  task automatic idle(input int ra0, input int ra1, input string name);
    cycle(1'b0, 0, '0, 1'b0, 0, ra0, ra1, name);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    for (int i = 0; i < 3; i++) idle(i, 31 - i, "reset_hold");
    rst_n = 1'b1;
    idle(0, 1, "reset_release");

    cycle(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 5, "write_r5");
    idle(5, 5, "read_r5");
    cycle(1'b1, 0, 32'h1234, 1'b0, 0, 0, 0, "write_r0");
    idle(0, 0, "read_r0");

    cycle(1'b0, 0, '0, 1'b1, 7, 7, 0, "issue_r7");
    cycle(1'b0, 0, '0, 1'b1, 7, 7, 7, "reissue_r7_blocked");
    cycle(1'b1, 7, 32'd9, 1'b0, 0, 7, 7, "write_r7");
    idle(7, 7, "read_r7");

    cycle(1'b0, 0, '0, 1'b1, 3, 3, 0, "issue_r3");
    cycle(1'b1, 3, 32'h33, 1'b1, 3, 3, 0, "release_reissue_r3");
    idle(3, 3, "r3_still_busy");

    cycle(1'b1, 4, 32'hAA, 1'b0, 0, 4, 1, "prep_r4");
    cycle(1'b1, 4, 32'h55, 1'b0, 0, 4, 4, "bypass_r4");
    idle(4, 4, "read_r4");

    cycle(1'b0, 0, '0, 1'b1, 0, 0, 0, "issue_r0");

    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, NR - 1), "random");
    end

    cycle(1'b1, 1, 32'h11, 1'b1, 1, 0, 0, "prep_busy_r1");
    cycle(1'b1, 2, 32'h22, 1'b1, 2, 0, 0, "prep_busy_r2");
    cycle(1'b1, 6, 32'h66, 1'b1, 6, 1, 2, "prep_busy_r6");
    cycle(1'b0, 0, '0, 1'b0, 0, 6, 1, "three_busy");
    rst_n = 1'b0;
    model_clear();
    idle(1, 2, "async_reset_1_2");
    idle(6, 5, "async_reset_6_5");
    rst_n = 1'b1;
    idle(1, 6, "after_reset_1_6");
    idle(2, 3, "after_reset_2_3");

    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
